// File: rtl/ws2812_bank_tx.sv
// Bank of WS2812 strip drivers sharing one pixel RAM and one bit-timing engine.
// Latency: first rising edge CHANNELS+2 cycles after accept; frame_start while busy is dropped, never queued.
module ws2812_bank_tx #(
    parameter int                  CHANNELS     = 8,
    parameter int                  LED_COUNT    = 320,
    parameter int                  ADDR_W       = 9,
    parameter int                  BIT_CYCLES   = 25,
    parameter int                  T0H_CYCLES   = 8,
    parameter int                  T1H_CYCLES   = 16,
    parameter int                  RESET_CYCLES = 1200,
    parameter logic [CHANNELS-1:0] REVERSE_MASK = '0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [4:0]          wr_channel_i,
    input  logic [ADDR_W-1:0]   wr_address_i,
    input  logic [7:0]          wr_r_i,
    input  logic [7:0]          wr_g_i,
    input  logic [7:0]          wr_b_i,
    input  logic [CHANNELS-1:0] channel_enable_i,
    input  logic                frame_start_i,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [CHANNELS-1:0] strip_o
);

    localparam int WORDS  = CHANNELS * LED_COUNT;
    localparam int RAM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = $clog2(CHANNELS + 1);
    localparam int PH_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES + 1) : 1;
    localparam int LAT_W  = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

    logic [23:0]       mem [WORDS];
    logic [23:0]       rd_data_q;
    logic [RAM_AW-1:0] wr_idx;
    logic [RAM_AW-1:0] rd_idx;
    logic              wr_ok;
    int                rd_ch;
    int                rd_led;
    logic              rev_sel;

    state_t                     state_q, state_d;
    logic                       pf_active_q, pf_active_d;
    logic [CNT_W-1:0]           pf_cnt_q, pf_cnt_d;
    logic [ADDR_W-1:0]          pf_slot_q, pf_slot_d;
    logic [CHANNELS-1:0][23:0]  shadow_q, shadow_d;
    logic [CHANNELS-1:0][23:0]  shift_q, shift_d;
    logic [CHANNELS-1:0][23:0]  cur_word;
    logic [PH_W-1:0]            phase_q, phase_d;
    logic [PH_W-1:0]            next_ph;
    logic [4:0]                 bit_q, bit_d;
    logic [ADDR_W-1:0]          slot_q, slot_d;
    logic [LAT_W-1:0]           lat_cnt_q, lat_cnt_d;
    logic [CHANNELS-1:0]        en_q, en_d;
    logic [CHANNELS-1:0]        strip_q, strip_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       load_now;

    assign wr_ok  = wr_en_i && (int'(wr_channel_i) < CHANNELS) && (int'(wr_address_i) < LED_COUNT);
    assign wr_idx = RAM_AW'(int'(wr_channel_i) * LED_COUNT + int'(wr_address_i));

    // Prefetch address: the channel counter selects both the RAM row and its reversal bit.
    always_comb begin
        rd_ch   = 0;
        rev_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(pf_cnt_q) == c) begin
                rd_ch   = c;
                rev_sel = REVERSE_MASK[c];
            end
        end
        rd_led = rev_sel ? (LED_COUNT - 1 - int'(pf_slot_q)) : int'(pf_slot_q);
        rd_idx = RAM_AW'(rd_ch * LED_COUNT + rd_led);
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_idx] <= {wr_g_i, wr_r_i, wr_b_i};
        end
        rd_data_q <= mem[rd_idx];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pf_active_q <= 1'b0;
            pf_cnt_q    <= '0;
            pf_slot_q   <= '0;
            shadow_q    <= '0;
            shift_q     <= '0;
            phase_q     <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            lat_cnt_q   <= '0;
            en_q        <= '0;
            strip_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pf_active_q <= pf_active_d;
            pf_cnt_q    <= pf_cnt_d;
            pf_slot_q   <= pf_slot_d;
            shadow_q    <= shadow_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            lat_cnt_q   <= lat_cnt_d;
            en_q        <= en_d;
            strip_q     <= strip_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // strip_d is the level for the next cycle, so output edges land exactly on register updates.
    always_comb begin
        state_d     = state_q;
        pf_active_d = pf_active_q;
        pf_cnt_d    = pf_cnt_q;
        pf_slot_d   = pf_slot_q;
        shadow_d    = shadow_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        lat_cnt_d   = lat_cnt_q;
        en_d        = en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        strip_d     = '0;
        load_now    = (state_q == SEND) && (bit_q == 5'd0) && (phase_q == '0);
        cur_word    = load_now ? shadow_q : shift_q;
        next_ph     = phase_q + PH_W'(1);

        if (pf_active_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(pf_cnt_q) == c + 1) begin
                    shadow_d[c] = rd_data_q;
                end
            end
            if (int'(pf_cnt_q) == CHANNELS) begin
                pf_active_d = 1'b0;
            end else begin
                pf_cnt_d = pf_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    en_d        = channel_enable_i;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                    pf_active_d = 1'b1;
                    pf_cnt_d    = '0;
                    pf_slot_d   = '0;
                end
            end
            LOAD: begin
                if (int'(pf_cnt_q) == CHANNELS) begin
                    state_d = SEND;
                    phase_d = '0;
                    bit_d   = '0;
                    slot_d  = '0;
                    strip_d = en_q;
                end
            end
            SEND: begin
                // Shadow is free once copied, so the next slot's prefetch starts right here.
                if (load_now) begin
                    shift_d = shadow_q;
                    if (int'(slot_q) < LED_COUNT - 1) begin
                        pf_active_d = 1'b1;
                        pf_cnt_d    = '0;
                        pf_slot_d   = slot_q + ADDR_W'(1);
                    end
                end
                if (int'(phase_q) == BIT_CYCLES - 1) begin
                    phase_d = '0;
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        if (int'(slot_q) == LED_COUNT - 1) begin
                            state_d   = LATCH;
                            lat_cnt_d = '0;
                        end else begin
                            slot_d  = slot_q + ADDR_W'(1);
                            strip_d = en_q;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                        for (int c = 0; c < CHANNELS; c++) begin
                            shift_d[c] = {cur_word[c][22:0], 1'b0};
                        end
                        strip_d = en_q;
                    end
                end else begin
                    phase_d = next_ph;
                    for (int c = 0; c < CHANNELS; c++) begin
                        strip_d[c] = en_q[c] & ((int'(next_ph) < T0H_CYCLES) |
                                                (cur_word[c][23] & (int'(next_ph) < T1H_CYCLES)));
                    end
                end
            end
            LATCH: begin
                if (int'(lat_cnt_q) == RESET_CYCLES - 1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign strip_o      = strip_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_ws2812_bank_tx.sv
// Bench for ws2812_bank_tx: random pixels, expected waveform computed from LED/bit timing arithmetic.
module tb_ws2812_bank_tx;

    localparam int          C    = 8;
    localparam int          L    = 3;
    localparam int          AW   = 9;
    localparam int          B    = 25;
    localparam int          T0   = 8;
    localparam int          T1   = 16;
    localparam int          R    = 1200;
    localparam logic [C-1:0] REV = 8'hA2;
    localparam int          FLEN = C + 1 + L * 24 * B + R + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_channel = '0;
    logic [AW-1:0] wr_address = '0;
    logic [7:0]    wr_r = '0, wr_g = '0, wr_b = '0;
    logic [C-1:0]  channel_enable = '0;
    logic          frame_start = 1'b0;
    logic          busy, frame_done;
    logic [C-1:0]  strip;

    int checks = 0;
    int errors = 0;
    logic [23:0] pix [C][L];

    ws2812_bank_tx #(
        .CHANNELS(C), .LED_COUNT(L), .ADDR_W(AW), .BIT_CYCLES(B),
        .T0H_CYCLES(T0), .T1H_CYCLES(T1), .RESET_CYCLES(R), .REVERSE_MASK(REV)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_channel_i(wr_channel),
        .wr_address_i(wr_address), .wr_r_i(wr_r), .wr_g_i(wr_g), .wr_b_i(wr_b),
        .channel_enable_i(channel_enable), .frame_start_i(frame_start),
        .busy_o(busy), .frame_done_o(frame_done), .strip_o(strip)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // k = cycles after the accept cycle; data starts at k = C+2.
    function automatic logic [C-1:0] exp_strip(input int k, input logic [C-1:0] en);
        logic [C-1:0] v;
        logic [23:0]  w;
        int o, slot, bitn, ph, led, hi;
        v = '0;
        o = k - (C + 2);
        if (o >= 0 && o < L * 24 * B) begin
            slot = o / (24 * B);
            bitn = (o % (24 * B)) / B;
            ph   = o % B;
            for (int c = 0; c < C; c++) begin
                led  = REV[c] ? (L - 1 - slot) : slot;
                w    = pix[c][led];
                hi   = w[23 - bitn] ? T1 : T0;
                v[c] = en[c] && (ph < hi);
            end
        end
        return v;
    endfunction

    task automatic wr(input int ch, input int a, input logic [23:0] grb);
        @(negedge clk);
        wr_en      = 1'b1;
        wr_channel = 5'(ch);
        wr_address = AW'(a);
        wr_g       = grb[23:16];
        wr_r       = grb[15:8];
        wr_b       = grb[7:0];
        @(negedge clk);
        wr_en = 1'b0;
        if (ch < C && a < L) pix[ch][a] = grb;
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < C; ch++)
            for (int a = 0; a < L; a++)
                wr(ch, a, 24'($urandom));
    endtask

    task automatic start(input logic [C-1:0] en);
        frame_start    = 1'b1;
        channel_enable = en;
    endtask

    // Caller has just driven the accepting frame_start at a negedge.
    task automatic watch_frame(input string tag, input logic [C-1:0] en, input int mid_k,
                               input bit chain, input logic [C-1:0] chain_en);
        int strip_bad, busy_bad, done_bad, first_k, last_k;
        strip_bad = 0; busy_bad = 0; done_bad = 0; first_k = -1;
        last_k = chain ? FLEN : FLEN + 3;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            frame_start = (k == mid_k);
            if (k == 1) channel_enable = ~en;
            if (strip !== exp_strip(k, en)) strip_bad++;
            if (busy !== (k < FLEN)) busy_bad++;
            if (frame_done !== (k == FLEN)) done_bad++;
            if (first_k < 0 && (strip & en) != '0) first_k = k;
            if (chain && k == FLEN) begin
                frame_start    = 1'b1;
                channel_enable = chain_en;
            end
        end
        check({tag, "_strip_bad_cycles"}, strip_bad, 0);
        check({tag, "_busy_bad_cycles"}, busy_bad, 0);
        check({tag, "_done_bad_cycles"}, done_bad, 0);
        check({tag, "_first_rise"}, first_k, C + 2);
    endtask

    initial begin
        logic [C-1:0] en;
        int done_seen, idle_bad, kr;

        repeat (3) @(negedge clk);
        check("reset_strip", strip, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Single red LED on channel 0 only.
        fill_random();
        wr(0, 0, 24'h00FF00);
        wr(0, 1, 24'h000000);
        @(negedge clk);
        start(8'h01);
        watch_frame("red_ch0", 8'h01, 0, 1'b0, '0);

        // Reversed channel 1 edge bits, mid-frame start ignored, back-to-back frame.
        fill_random();
        wr(1, 2, {8'h80, 16'($urandom)});
        wr(1, 0, {8'h01, 16'($urandom)});
        en = C'($urandom) | 8'h03;
        @(negedge clk);
        start(en);
        watch_frame("rev_mid", en, C + 2 + 800, 1'b1, 8'hFF);
        watch_frame("chained", 8'hFF, 0, 1'b0, '0);

        // Out-of-range writes must leave every stored pixel untouched.
        wr(9, 0, 24'h123456);
        wr(8, 1, 24'h654321);
        wr(0, L, 24'hABCDEF);
        wr(2, L, 24'hFEDCBA);
        wr(5, 511, 24'h777777);
        @(negedge clk);
        start(8'hFF);
        watch_frame("bad_writes", 8'hFF, 0, 1'b0, '0);

        // Reset mid-SEND while enabled outputs are in a high phase.
        fill_random();
        en = C'($urandom) | 8'h10;
        @(negedge clk);
        start(en);
        kr = C + 2 + 24 * B + 3;
        for (int k = 1; k <= kr; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
        end
        check("pre_reset_strip", strip, exp_strip(kr, en));
        rst_n = 1'b0;
        #1;
        check("mid_reset_strip", strip, 0);
        check("mid_reset_busy", busy, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_done !== 1'b0) done_seen++;
            if (busy !== 1'b0 || strip !== '0) idle_bad++;
        end
        check("reset_no_done", done_seen, 0);
        check("post_reset_idle_bad_cycles", idle_bad, 0);
        en = C'($urandom) | 8'h01;
        start(en);
        watch_frame("after_reset", en, 0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
